// File: rtl/micro_seq_pkg.sv
// Shared encodings and microcode word layout helpers for micro_sequencer.
// Word layout, MSB first: {ctrl, src1, src2, dest, opcode}.
package micro_seq_pkg;

  typedef enum logic [1:0] {
    CTRL_EXEC = 2'b00,
    CTRL_LOOP = 2'b01,
    CTRL_HALT = 2'b10,
    CTRL_NOP  = 2'b11
  } ctrl_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned CTRL_W = 2;

  function automatic int unsigned ofs_dest(int unsigned op_w);
    return op_w;
  endfunction

  function automatic int unsigned ofs_src2(int unsigned reg_aw, int unsigned op_w);
    return op_w + reg_aw;
  endfunction

  function automatic int unsigned ofs_src1(int unsigned reg_aw, int unsigned op_w);
    return op_w + 2 * reg_aw;
  endfunction

  function automatic int unsigned ofs_ctrl(int unsigned reg_aw, int unsigned op_w);
    return op_w + 3 * reg_aw;
  endfunction

  function automatic int unsigned word_w(int unsigned reg_aw, int unsigned op_w);
    return ofs_ctrl(reg_aw, op_w) + CTRL_W;
  endfunction

  function automatic int unsigned pc_w(int unsigned nsteps);
    return (nsteps > 1) ? $clog2(nsteps) : 1;
  endfunction

endpackage

// File: rtl/micro_store.sv
// Microcode store: NSTEPS x UW register array, synchronous write, combinational read.
// Contents are deliberately not reset so a program survives rst_n.
module micro_store
  import micro_seq_pkg::*;
#(
  parameter int unsigned NSTEPS = 8,
  parameter int unsigned UW     = 15,
  parameter int unsigned PC_W   = 3
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [PC_W-1:0] waddr_i,
  input  logic [UW-1:0]   wdata_i,
  input  logic [PC_W-1:0] raddr_i,
  output logic [UW-1:0]   rdata_o
);

  logic [UW-1:0] mem_q [NSTEPS];

  always_ff @(posedge clk_i) begin
    if (we_i && (32'(waddr_i) < NSTEPS)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (32'(raddr_i) < NSTEPS) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/micro_sequencer.sv
// Loadable microprogram sequencer driving src1/src2/dest/opcode/WR with start/busy/done.
// Optional run-length watchdog enabled by defining MICRO_SEQ_WDOG_EN.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter  int unsigned REG_AW  = 3,
  parameter  int unsigned OP_W    = 4,
  parameter  int unsigned NSTEPS  = 8,
  parameter  int unsigned MAX_RUN = 255,
  localparam int unsigned PC_W    = pc_w(NSTEPS),
  localparam int unsigned UW      = word_w(REG_AW, OP_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flag_zero,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [UW-1:0]     prog_data,
  output logic [REG_AW-1:0] src1,
  output logic [REG_AW-1:0] src2,
  output logic [REG_AW-1:0] dest,
  output logic [OP_W-1:0]   opcode,
  output logic              WR,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned OFS_DEST = ofs_dest(OP_W);
  localparam int unsigned OFS_SRC2 = ofs_src2(REG_AW, OP_W);
  localparam int unsigned OFS_SRC1 = ofs_src1(REG_AW, OP_W);
  localparam int unsigned OFS_CTRL = ofs_ctrl(REG_AW, OP_W);
  // pc is one bit wider than the store address so "past the last word" is representable.
  localparam logic [PC_W:0] PC_END = (PC_W+1)'(NSTEPS);

  state_e            state_q, state_d;
  logic [PC_W:0]     pc_q, pc_d;
  logic [REG_AW-1:0] src1_q, src1_d, src2_q, src2_d, dest_q, dest_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic              wr_q, wr_d;
  logic [UW-1:0]     word;
  ctrl_e             ctrl;
  logic              store_we;
  logic              run_entry;
  logic              wdog_trip;

  assign store_we  = prog_we && (state_q != S_RUN);
  assign run_entry = start && (state_q != S_RUN);

  micro_store #(
    .NSTEPS (NSTEPS),
    .UW     (UW),
    .PC_W   (PC_W)
  ) u_store (
    .clk_i   (clk),
    .we_i    (store_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (pc_q[PC_W-1:0]),
    .rdata_o (word)
  );

  assign ctrl = ctrl_e'(word[OFS_CTRL +: CTRL_W]);

`ifdef MICRO_SEQ_WDOG_EN
  localparam int unsigned WD_W = $clog2(MAX_RUN + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_RUN - 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            err_q, err_d;

  assign wdog_trip = (state_q == S_RUN) && (wdog_q == WD_LAST);

  always_comb begin
    wdog_d = wdog_q;
    err_d  = err_q;
    if (run_entry) begin
      wdog_d = '0;
      err_d  = 1'b0;
    end else if (state_q == S_RUN) begin
      wdog_d = wdog_q + 1'b1;
      if (wdog_trip) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign wdog_trip = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    dest_d   = dest_q;
    opcode_d = opcode_q;
    wr_d     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      S_RUN: begin
        // The last word's WR pulse completes before DONE, so DONE always opens with WR=0.
        if (wdog_trip || (pc_q == PC_END)) begin
          state_d = S_DONE;
        end else begin
          case (ctrl)
            CTRL_EXEC, CTRL_LOOP: begin
              src1_d   = word[OFS_SRC1 +: REG_AW];
              src2_d   = word[OFS_SRC2 +: REG_AW];
              dest_d   = word[OFS_DEST +: REG_AW];
              opcode_d = word[OP_W-1:0];
              wr_d     = 1'b1;
              pc_d     = ((ctrl == CTRL_LOOP) && !flag_zero) ? '0 : pc_q + 1'b1;
            end
            CTRL_HALT: state_d = S_DONE;
            default:   pc_d = pc_q + 1'b1;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      dest_q   <= '0;
      opcode_q <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      dest_q   <= dest_d;
      opcode_q <= opcode_d;
      wr_q     <= wr_d;
    end
  end

  assign src1   = src1_q;
  assign src2   = src2_q;
  assign dest   = dest_q;
  assign opcode = opcode_q;
  assign WR     = wr_q;
  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: expected WR field tuples queued by stimulus,
// popped by a negedge monitor on every WR cycle.
module tb_micro_sequencer;
  import micro_seq_pkg::*;

  localparam int unsigned AW = 3;
  localparam int unsigned OW = 4;
  localparam int unsigned NS = 8;
  localparam int unsigned PW = 3;
  localparam int unsigned UW = 15;
  localparam int unsigned FW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          flag_zero = 1'b0;
  logic          prog_we = 1'b0;
  logic [PW-1:0] prog_addr = '0;
  logic [UW-1:0] prog_data = '0;
  logic [AW-1:0] src1, src2, dest;
  logic [OW-1:0] opcode;
  logic          WR, busy, done, err;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int cyc;
  logic [FW-1:0] sb[$];
  logic [FW-1:0] mon_exp;
  logic [UW-1:0] wa, wb, wc, wh, wl, wx, wd;

  micro_sequencer #(
    .REG_AW  (AW),
    .OP_W    (OW),
    .NSTEPS  (NS),
    .MAX_RUN (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .flag_zero (flag_zero),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .src1      (src1),
    .src2      (src2),
    .dest      (dest),
    .opcode    (opcode),
    .WR        (WR),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [UW-1:0] mk(ctrl_e c, int s1, int s2, int d, int op);
    return {c, AW'(s1), AW'(s2), AW'(d), OW'(op)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input int a, input logic [UW-1:0] w);
    prog_we   = 1'b1;
    prog_addr = PW'(a);
    prog_data = w;
    step();
    prog_we   = 1'b0;
  endtask

  task automatic push(input logic [UW-1:0] w);
    sb.push_back(w[FW-1:0]);
  endtask

  task automatic do_start();
    wr_count = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, n);
    end
  endtask

  always @(negedge clk) begin
    if (WR === 1'b1) begin
      wr_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr: got fields %0h with WR=1, required no write", {src1, src2, dest, opcode});
      end else begin
        mon_exp = sb.pop_front();
        chk("wr_fields", 32'({src1, src2, dest, opcode}), 32'(mon_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    wa = mk(CTRL_EXEC, 1, 2, 3, 4'h1);
    wb = mk(CTRL_EXEC, 4, 5, 6, 4'h2);
    wc = mk(CTRL_EXEC, 7, 0, 1, 4'h3);
    wh = mk(CTRL_HALT, 2, 2, 2, 4'hF);
    wl = mk(CTRL_LOOP, 3, 3, 5, 4'h7);
    wx = mk(CTRL_EXEC, 6, 6, 6, 4'h9);
    wd = mk(CTRL_EXEC, 5, 1, 7, 4'hC);

    repeat (2) step();
    chk("reset_ctrl", 32'({WR, busy, done, err}), 0);
    chk("reset_fields", 32'({src1, src2, dest, opcode}), 0);
    rst_n = 1'b1;
    step();

    // three EXEC words then HALT
    wr_word(0, wa); wr_word(1, wb); wr_word(2, wc); wr_word(3, wh);
    push(wa); push(wb); push(wc);
    do_start();
    chk("t1_busy", 32'(busy), 1);
    wait_done(20, cyc);
    chk("t1_cycles", cyc, 4);
    chk("t1_wr_count", wr_count, 3);
    chk("t1_done_ctrl", 32'({WR, busy, done}), 32'(3'b001));
    chk("t1_hold", 32'({src1, src2, dest, opcode}), 32'(wc[FW-1:0]));
    chk("t1_sb", sb.size(), 0);

    // HALT at word 2
    wr_word(2, wh);
    push(wa); push(wb);
    do_start();
    wait_done(20, cyc);
    chk("t2_cycles", cyc, 3);
    chk("t2_wr_count", wr_count, 2);
    chk("t2_hold", 32'({src1, src2, dest, opcode}), 32'(wb[FW-1:0]));
    chk("t2_sb", sb.size(), 0);

    // LOOP at word 1: taken twice, then falls through
    wr_word(1, wl); wr_word(2, wc);
    push(wa); push(wl); push(wa); push(wl); push(wa); push(wl); push(wc);
    flag_zero = 1'b0;
    do_start();
    repeat (5) step();
    flag_zero = 1'b1;
    wait_done(20, cyc);
    flag_zero = 1'b0;
    chk("t3_cycles", cyc + 5, 8);
    chk("t3_wr_count", wr_count, 7);
    chk("t3_sb", sb.size(), 0);

    // prog_we and start during RUN are ignored
    wr_word(1, wb);
    push(wa); push(wb); push(wc);
    do_start();
    prog_we = 1'b1; prog_addr = 3'd1; prog_data = wx; start = 1'b1;
    step();
    prog_we = 1'b0; start = 1'b0;
    wait_done(20, cyc);
    chk("t4_cycles", cyc + 1, 4);
    chk("t4_sb", sb.size(), 0);
    push(wa); push(wb); push(wc);
    do_start();
    wait_done(20, cyc);
    chk("t4_readback_cycles", cyc, 4);
    chk("t4_readback_sb", sb.size(), 0);

    // same-edge start and write: step 0 uses the new word
    push(wd); push(wb); push(wc);
    wr_count = 0;
    prog_we = 1'b1; prog_addr = 3'd0; prog_data = wd; start = 1'b1;
    step();
    prog_we = 1'b0; start = 1'b0;
    wait_done(20, cyc);
    chk("t4b_cycles", cyc, 4);
    chk("t4b_sb", sb.size(), 0);

    // reset mid-run
    push(wd);
    do_start();
    step(); step();
    chk("t5_wr_before", 32'(WR), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_ctrl", 32'({WR, busy, done}), 0);
    chk("t5_async_fields", 32'({src1, src2, dest, opcode}), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("t5_sb", sb.size(), 0);
    push(wd); push(wb); push(wc);
    do_start();
    wait_done(20, cyc);
    chk("t5_restart_cycles", cyc, 4);
    chk("t5_restart_sb", sb.size(), 0);

    // full store of EXEC words: runs off the end into DONE
    for (int i = 0; i < NS; i++) begin
      wr_word(i, mk(CTRL_EXEC, i, 7 - i, i ^ 3, i + 8));
      push(mk(CTRL_EXEC, i, 7 - i, i ^ 3, i + 8));
    end
    do_start();
    wait_done(30, cyc);
    chk("t6_cycles", cyc, 9);
    chk("t6_wr_count", wr_count, 8);
    chk("t6_wr_done", 32'(WR), 0);
    chk("t6_hold", 32'({src1, src2, dest, opcode}), 32'({3'd7, 3'd0, 3'd4, 4'hF}));
    chk("t6_sb", sb.size(), 0);

    // endless LOOP at word 0
    wr_word(0, wl);
    flag_zero = 1'b0;
`ifdef MICRO_SEQ_WDOG_EN
    repeat (9) push(wl);
    do_start();
    wait_done(30, cyc);
    chk("t7_wdog_cycles", cyc, 10);
    chk("t7_wdog_err", 32'(err), 1);
    chk("t7_wdog_wr", 32'(WR), 0);
    chk("t7_wdog_wr_count", wr_count, 9);
    chk("t7_wdog_sb", sb.size(), 0);
    do_start();
    chk("t7_err_cleared", 32'({err, busy}), 32'(2'b01));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
`else
    repeat (29) push(wl);
    do_start();
    repeat (30) step();
    chk("t7_still_running", 32'({busy, done, err}), 32'(3'b100));
    rst_n = 1'b0;
    #1;
    chk("t7_reset_wr", 32'({WR, busy}), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("t7_sb", sb.size(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
